// File: rtl/mcc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit Multi_Cycle_Computer: sequences each instruction,
// arbitrates the unified memory by req/ready, counts retired instructions and stops on fault or HALT.
module mcc_control_fsm #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             bus_error,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,  S_WB_I   = 4'd5,  S_ADDR   = 4'd6,  S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_count;
    logic             r_bus_err;
    logic             w_retire;
    logic             w_timeout;

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_timeout  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                w_timeout = !mem_ready && (r_wait == TO_LAST);
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd2;
                case (opcode)
                    4'h0:       w_next = S_EXEC_R;
                    4'h1:       w_next = S_EXEC_I;
                    4'h2, 4'h3: w_next = S_ADDR;
                    4'h4:       w_next = S_BRANCH;
                    4'h5:       w_next = S_JUMP;
                    4'hF: begin
                        w_next   = S_HALT;
                        w_retire = 1'b1;
                    end
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                w_next    = S_WB_R;
            end
            S_WB_R: begin
                reg_we   = 1'b1;
                reg_dst  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (r_state == S_EXEC_I) w_next = S_WB_I;
                else                     w_next = (opcode == 4'h3) ? S_MEM_WR : S_MEM_RD;
            end
            S_WB_I: begin
                reg_we   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_we    = (r_state == S_MEM_WR);
                w_timeout = !mem_ready && (r_wait == TO_LAST);
                if (mem_ready) begin
                    // A store retires once the write commits; a load still has writeback
                    w_retire = (r_state == S_MEM_WR);
                    w_next   = (r_state == S_MEM_WR) ? S_FETCH : S_WB_MEM;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd1;
                pc_src    = 2'd1;
                pc_we     = alu_zero;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_we    = 1'b1;
                pc_src   = 2'd2;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
        // Architectural writes are suppressed while reset is held
        if (reset) begin
            ir_we  = 1'b0;
            pc_we  = 1'b0;
            reg_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_wait    <= 8'd0;
            r_count   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)  r_count   <= r_count + CNT_W'(1);
            if (w_timeout) r_bus_err <= 1'b1;
            // Wait count restarts whenever the FSM moves to a new state
            if (w_next != r_state)           r_wait <= 8'd0;
            else if (mem_req && !mem_ready)  r_wait <= r_wait + 8'd1;
        end
    end

    assign halted      = (r_state == S_HALT);
    assign bus_error   = r_bus_err;
    assign instr_count = r_count;
    assign state       = r_state;

endmodule

// File: tb/tb_mcc_control_fsm.sv
// Directed bench for mcc_control_fsm: vector table for whole instructions plus hand-written
// sequences for memory timeout, ready-on-last-cycle, reset mid-access and HALT persistence.
module tb_mcc_control_fsm;

    logic        clock, reset, alu_zero, mem_ready;
    logic [3:0]  opcode;
    logic        mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, reg_we, reg_dst, mem_to_reg;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic        halted, bus_error, illegal_op;
    logic [15:0] instr_count;
    logic [3:0]  state;

    mcc_control_fsm #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .halted(halted), .bus_error(bus_error),
        .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ctl = {req,we,iord}_{ir_we,pc_we}_{pc_src}_{asa}_{asb}_{aop}_{reg_we,reg_dst,m2r}
    localparam logic [14:0] C_F1  = 15'b100_11_00_0_01_00_000;
    localparam logic [14:0] C_F0  = 15'b100_00_00_0_01_00_000;
    localparam logic [14:0] C_DEC = 15'b000_00_00_0_10_00_000;
    localparam logic [14:0] C_XR  = 15'b000_00_00_1_00_10_000;
    localparam logic [14:0] C_WR  = 15'b000_00_00_0_00_00_110;
    localparam logic [14:0] C_XI  = 15'b000_00_00_1_10_00_000;
    localparam logic [14:0] C_WI  = 15'b000_00_00_0_00_00_100;
    localparam logic [14:0] C_MR  = 15'b101_00_00_0_00_00_000;
    localparam logic [14:0] C_MW  = 15'b111_00_00_0_00_00_000;
    localparam logic [14:0] C_WM  = 15'b000_00_00_0_00_00_101;
    localparam logic [14:0] C_B1  = 15'b000_01_01_1_00_01_000;
    localparam logic [14:0] C_B0  = 15'b000_00_01_1_00_01_000;
    localparam logic [14:0] C_J   = 15'b000_01_10_0_00_00_000;
    localparam logic [14:0] C_H   = 15'b000_00_00_0_00_00_000;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [2:0]  flg;   // {illegal_op, halted, bus_error}
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic rst, input logic [3:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [14:0] ctl, input logic [2:0] flg,
                       input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.flg = flg; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] op, input logic z, input logic rdy);
        reset = rst; opcode = op; alu_zero = z; mem_ready = rdy;
        #4;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] ctl_now();
        return {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                alu_op, reg_we, reg_dst, mem_to_reg};
    endfunction

    initial begin
        reset = 1'b1; opcode = 4'h0; alu_zero = 1'b0; mem_ready = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) add(1, 4'h0, 0, 1, 4'd0, C_F0, 3'b000, 16'd0);
        // R-type
        add(0, 4'h0, 0, 1, 4'd0, C_F1, 3'b000, 16'd0);
        add(0, 4'h0, 0, 1, 4'd1, C_DEC, 3'b000, 16'd0);
        add(0, 4'h0, 0, 1, 4'd2, C_XR, 3'b000, 16'd0);
        add(0, 4'h0, 0, 1, 4'd3, C_WR, 3'b000, 16'd0);
        // ADDI
        add(0, 4'h1, 0, 1, 4'd0, C_F1, 3'b000, 16'd1);
        add(0, 4'h1, 0, 1, 4'd1, C_DEC, 3'b000, 16'd1);
        add(0, 4'h1, 0, 1, 4'd4, C_XI, 3'b000, 16'd1);
        add(0, 4'h1, 0, 1, 4'd5, C_WI, 3'b000, 16'd1);
        // LW zero-wait
        add(0, 4'h2, 0, 1, 4'd0, C_F1, 3'b000, 16'd2);
        add(0, 4'h2, 0, 1, 4'd1, C_DEC, 3'b000, 16'd2);
        add(0, 4'h2, 0, 1, 4'd6, C_XI, 3'b000, 16'd2);
        add(0, 4'h2, 0, 1, 4'd7, C_MR, 3'b000, 16'd2);
        add(0, 4'h2, 0, 1, 4'd9, C_WM, 3'b000, 16'd2);
        // SW zero-wait
        add(0, 4'h3, 0, 1, 4'd0, C_F1, 3'b000, 16'd3);
        add(0, 4'h3, 0, 1, 4'd1, C_DEC, 3'b000, 16'd3);
        add(0, 4'h3, 0, 1, 4'd6, C_XI, 3'b000, 16'd3);
        add(0, 4'h3, 0, 1, 4'd8, C_MW, 3'b000, 16'd3);
        // BEQ taken, then not taken
        add(0, 4'h4, 1, 1, 4'd0, C_F1, 3'b000, 16'd4);
        add(0, 4'h4, 1, 1, 4'd1, C_DEC, 3'b000, 16'd4);
        add(0, 4'h4, 1, 1, 4'd10, C_B1, 3'b000, 16'd4);
        add(0, 4'h4, 0, 1, 4'd0, C_F1, 3'b000, 16'd5);
        add(0, 4'h4, 0, 1, 4'd1, C_DEC, 3'b000, 16'd5);
        add(0, 4'h4, 0, 1, 4'd10, C_B0, 3'b000, 16'd5);
        // JMP
        add(0, 4'h5, 0, 1, 4'd0, C_F1, 3'b000, 16'd6);
        add(0, 4'h5, 0, 1, 4'd1, C_DEC, 3'b000, 16'd6);
        add(0, 4'h5, 0, 1, 4'd11, C_J, 3'b000, 16'd6);
        // Illegal opcode 7: pulse in DECODE, not retired
        add(0, 4'h7, 0, 1, 4'd0, C_F1, 3'b000, 16'd7);
        add(0, 4'h7, 0, 1, 4'd1, C_DEC, 3'b100, 16'd7);
        // LW with three wait cycles in MEM_RD: 8 cycles total
        add(0, 4'h2, 0, 1, 4'd0, C_F1, 3'b000, 16'd7);
        add(0, 4'h2, 0, 1, 4'd1, C_DEC, 3'b000, 16'd7);
        add(0, 4'h2, 0, 1, 4'd6, C_XI, 3'b000, 16'd7);
        for (int i = 0; i < 3; i++) add(0, 4'h2, 0, 0, 4'd7, C_MR, 3'b000, 16'd7);
        add(0, 4'h2, 0, 1, 4'd7, C_MR, 3'b000, 16'd7);
        add(0, 4'h2, 0, 1, 4'd9, C_WM, 3'b000, 16'd7);
        // ADDI with two fetch wait cycles
        add(0, 4'h1, 0, 0, 4'd0, C_F0, 3'b000, 16'd8);
        add(0, 4'h1, 0, 0, 4'd0, C_F0, 3'b000, 16'd8);
        add(0, 4'h1, 0, 1, 4'd0, C_F1, 3'b000, 16'd8);
        add(0, 4'h1, 0, 1, 4'd1, C_DEC, 3'b000, 16'd8);
        add(0, 4'h1, 0, 1, 4'd4, C_XI, 3'b000, 16'd8);
        add(0, 4'h1, 0, 1, 4'd5, C_WI, 3'b000, 16'd8);
        // HALT retires on entry and stays
        add(0, 4'hF, 0, 1, 4'd0, C_F1, 3'b000, 16'd9);
        add(0, 4'hF, 0, 1, 4'd1, C_DEC, 3'b000, 16'd9);
        for (int i = 0; i < 3; i++) add(0, 4'hF, 0, 1, 4'd12, C_H, 3'b010, 16'd10);
        add(1, 4'hF, 0, 1, 4'd12, C_H, 3'b010, 16'd10);
        add(0, 4'h0, 0, 0, 4'd0, C_F0, 3'b000, 16'd0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].op, vq[i].z, vq[i].rdy);
            chk($sformatf("row%0d", i),
                {26'd0, state, ctl_now(), illegal_op, halted, bus_error, instr_count},
                {26'd0, vq[i].st, vq[i].ctl, vq[i].flg, vq[i].cnt});
            tick();
        end

        // Fetch timeout after one retired JMP: 14 waits survive, the 15th halts
        drive(1, 4'h0, 0, 1); tick();
        for (int i = 0; i < 3; i++) begin drive(0, 4'h5, 0, 1); tick(); end
        for (int i = 0; i < 14; i++) begin drive(0, 4'h5, 0, 0); tick(); end
        drive(0, 4'h5, 0, 0);
        chk("to_before", {state, bus_error, halted, mem_req}, {4'd0, 1'b0, 1'b0, 1'b1});
        tick();
        drive(0, 4'h5, 0, 1);
        chk("to_after", {state, bus_error, halted, mem_req}, {4'd12, 1'b1, 1'b1, 1'b0});
        chk("to_count", instr_count, 16'd1);
        tick(); tick();
        drive(0, 4'h5, 0, 1);
        chk("to_sticky", {state, bus_error}, {4'd12, 1'b1});
        drive(1, 4'h5, 0, 1); tick();
        drive(0, 4'h2, 0, 1);
        chk("to_reset", {state, bus_error, halted, instr_count}, {4'd0, 1'b0, 1'b0, 16'd0});

        // LW: ready on the 15th MEM_RD cycle wins over timeout
        for (int i = 0; i < 3; i++) begin drive(0, 4'h2, 0, 1); tick(); end
        for (int i = 0; i < 14; i++) begin
            drive(0, 4'h2, 0, 0);
            chk($sformatf("rd_hold%0d", i), {state, mem_req, iord, mem_we}, {4'd7, 3'b110});
            tick();
        end
        drive(0, 4'h2, 0, 1); tick();
        drive(0, 4'h2, 0, 1);
        chk("rd_last_ready", {state, bus_error, mem_to_reg, reg_we}, {4'd9, 1'b0, 1'b1, 1'b1});
        tick();
        drive(0, 4'h3, 0, 1);
        chk("rd_retired", {state, instr_count}, {4'd0, 16'd1});

        // SW: reset during a write wait returns to FETCH
        for (int i = 0; i < 3; i++) begin drive(0, 4'h3, 0, 1); tick(); end
        for (int i = 0; i < 2; i++) begin drive(0, 4'h3, 0, 0); tick(); end
        drive(1, 4'h3, 0, 0);
        chk("wr_wait", {state, mem_we, instr_count}, {4'd8, 1'b1, 16'd1});
        tick();
        drive(0, 4'h3, 0, 0);
        chk("wr_reset", {state, mem_req, mem_we, iord, instr_count}, {4'd0, 3'b100, 16'd0});
        tick();

        // HALT holds for 22 cycles with mem_req low even while mem_ready toggles
        drive(0, 4'hF, 0, 1); tick();
        drive(0, 4'hF, 0, 1); tick();
        for (int i = 0; i < 22; i++) begin
            drive(0, 4'hF, 0, 1'(i % 2));
            chk($sformatf("halt%0d", i), {state, halted, mem_req, ir_we, pc_we, reg_we, instr_count},
                {4'd12, 5'b10000, 16'd1});
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
